// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: serial-transmit controller producing 8N1-style frames
// (start bit, DATA_BITS data bits LSB first, stop bit) from a parallel byte.
// Optional build macro UART_TX_PARITY_EN inserts one even-parity bit between
// the last data bit and the stop bit.
// All outputs are registered; there is no combinational input-to-output path.
module uart_tx_ctrl #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic                 tx_serial
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [BW-1:0] BCNT_MAX = BW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] BIDX_MAX = IW'(DATA_BITS - 1);
  // Index of the bit that becomes sh_r[0] after the next shift.
  localparam int NXT_IDX = (DATA_BITS > 1) ? 1 : 0;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction
`else
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd4
  } state_t;
`endif

  state_t               state_r;
  logic [BW-1:0]        bcnt_r;
  logic [IW-1:0]        bidx_r;
  logic [DATA_BITS-1:0] sh_r;
  logic                 busy_r;
  logic                 done_r;
  logic                 serial_r;
  logic                 tick_s;
`ifdef UART_TX_PARITY_EN
  logic                 par_r;
`endif

  // Bit-end tick: last clock of the current serial bit period.
  always_comb begin
    tick_s = (bcnt_r == BCNT_MAX);
  end

  // Frame sequencer: state, counters, shift register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      bcnt_r   <= '0;
      bidx_r   <= '0;
      sh_r     <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      serial_r <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_r    <= 1'b0;
`endif
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          bcnt_r <= '0;
          bidx_r <= '0;
          if (tx_start) begin
            sh_r     <= tx_data;
`ifdef UART_TX_PARITY_EN
            par_r    <= even_parity(tx_data);
`endif
            state_r  <= START;
            serial_r <= 1'b0;
            busy_r   <= 1'b1;
          end else begin
            serial_r <= 1'b1;
            busy_r   <= 1'b0;
          end
        end

        START: begin
          if (tick_s) begin
            bcnt_r   <= '0;
            bidx_r   <= '0;
            state_r  <= DATA;
            serial_r <= sh_r[0];
          end else begin
            bcnt_r   <= bcnt_r + BW'(1);
          end
        end

        DATA: begin
          if (tick_s) begin
            bcnt_r <= '0;
            sh_r   <= sh_r >> 1;
            if (bidx_r == BIDX_MAX) begin
`ifdef UART_TX_PARITY_EN
              state_r  <= PARITY;
              serial_r <= par_r;
`else
              state_r  <= STOP;
              serial_r <= 1'b1;
`endif
            end else begin
              bidx_r   <= bidx_r + IW'(1);
              serial_r <= sh_r[NXT_IDX];
            end
          end else begin
            bcnt_r <= bcnt_r + BW'(1);
          end
        end

`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (tick_s) begin
            bcnt_r   <= '0;
            state_r  <= STOP;
            serial_r <= 1'b1;
          end else begin
            bcnt_r   <= bcnt_r + BW'(1);
          end
        end
`endif

        STOP: begin
          if (tick_s) begin
            // First IDLE cycle carries the done pulse; busy drops at once.
            bcnt_r   <= '0;
            state_r  <= IDLE;
            serial_r <= 1'b1;
            busy_r   <= 1'b0;
            done_r   <= 1'b1;
          end else begin
            bcnt_r   <= bcnt_r + BW'(1);
          end
        end

        default: begin
          state_r  <= IDLE;
          bcnt_r   <= '0;
          bidx_r   <= '0;
          busy_r   <= 1'b0;
          serial_r <= 1'b1;
        end
      endcase
    end
  end

  assign tx_busy   = busy_r;
  assign tx_done   = done_r;
  assign tx_serial = serial_r;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl with CLKS_PER_BIT=4.
// Expected line behaviour comes from a frame model built from bit positions.
module tb_uart_tx_ctrl;

  localparam int N  = 4;
  localparam int DB = 8;
`ifdef UART_TX_PARITY_EN
  localparam int NB = DB + 3;
`else
  localparam int NB = DB + 2;
`endif
  localparam int FL = NB * N;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_serial;

  int pass_cnt  = 0;
  int check_cnt = 0;

  // Observed {serial, busy, done} indexed by cycle offset from the accept edge.
  logic [2:0] obs [0:255];

  uart_tx_ctrl #(.CLKS_PER_BIT(N), .DATA_BITS(DB)) dut (
    .clk      (clk),
    .rst      (rst),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done),
    .tx_serial(tx_serial)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model: line state k cycles after the accepting edge of a lone frame.
  function automatic logic [2:0] exp_frame(input logic [7:0] d, input int k);
    int idx;
    if (k < 1 || k > FL) return (k == FL + 1) ? 3'b101 : 3'b100;
    idx = (k - 1) / N;
    if (idx == 0) return 3'b010;
    if (idx <= DB) return {d[idx-1], 2'b10};
    if (NB == DB + 3 && idx == DB + 1) return {^d, 2'b10};
    return 3'b110;
  endfunction

  // Accept a frame: tx_start sampled at edge E; returns in cycle E+1.
  task automatic launch(input logic [7:0] d);
    tx_data  = d;
    tx_start = 1'b1;
    step();
    tx_start = 1'b0;
  endtask

  // Record n cycles; optionally pulse tx_start or rst during a given cycle.
  task automatic capture(input int n, input int start_at, input logic [7:0] sd,
                         input int rst_at);
    for (int k = 1; k <= n; k++) begin
      obs[k]   = {tx_serial, tx_busy, tx_done};
      tx_start = (k == start_at);
      tx_data  = (k == start_at) ? sd : 8'($urandom);
      rst      = (k == rst_at);
      step();
    end
    tx_start = 1'b0;
    rst      = 1'b0;
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    tx_start = 1'b1;
    tx_data  = 8'($urandom);
    for (int i = 0; i < 3; i++) begin
      step();
      check_cnt++;
      if ({tx_serial, tx_busy, tx_done} !== 3'b100)
        $display("FAIL reset cyc%0d: serial/busy/done got %b want 100", i,
                 {tx_serial, tx_busy, tx_done});
      else pass_cnt++;
    end
    rst      = 1'b0;
    tx_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check_cnt++;
      if ({tx_serial, tx_busy, tx_done} !== 3'b100)
        $display("FAIL reset_idle cyc%0d: serial/busy/done got %b want 100", i,
                 {tx_serial, tx_busy, tx_done});
      else pass_cnt++;
    end
  endtask

  task automatic test_single(input logic [7:0] d);
    logic [2:0] e;
    launch(d);
    capture(FL + 4, -1, 8'h00, -1);
    for (int k = 1; k <= FL + 4; k++) begin
      e = exp_frame(d, k);
      check_cnt++;
      if (obs[k] !== e)
        $display("FAIL single d=%h k=%0d: serial/busy/done got %b want %b", d, k, obs[k], e);
      else pass_cnt++;
    end
  endtask

  task automatic test_busy_ignore();
    logic [2:0] e;
    launch(8'h3C);
    capture(2 * FL + 4, 10, 8'hFF, -1);
    for (int k = 1; k <= 2 * FL + 4; k++) begin
      e = exp_frame(8'h3C, k);
      check_cnt++;
      if (obs[k] !== e)
        $display("FAIL busy_ignore k=%0d: serial/busy/done got %b want %b", k, obs[k], e);
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] e;
    launch(8'h00);
    capture(2 * FL + 4, FL + 1, 8'hFF, -1);
    for (int k = 1; k <= 2 * FL + 4; k++) begin
      e = (k <= FL + 1) ? exp_frame(8'h00, k) : exp_frame(8'hFF, k - FL - 1);
      check_cnt++;
      if (obs[k] !== e)
        $display("FAIL back_to_back k=%0d: serial/busy/done got %b want %b", k, obs[k], e);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [2:0] e;
    logic [7:0] d2;
    d2 = 8'($urandom);
    launch(8'h55);
    capture(20 + FL + 3, 20, d2, 17);
    for (int k = 1; k <= 20 + FL + 3; k++) begin
      if (k <= 17)      e = exp_frame(8'h55, k);
      else if (k <= 20) e = 3'b100;
      else              e = exp_frame(d2, k - 20);
      check_cnt++;
      if (obs[k] !== e)
        $display("FAIL reset_mid k=%0d: serial/busy/done got %b want %b", k, obs[k], e);
      else pass_cnt++;
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity(input logic [7:0] d, input logic pbit);
    launch(d);
    capture(FL + 2, -1, 8'h00, -1);
    for (int k = 37; k <= 40; k++) begin
      check_cnt++;
      if (obs[k][2] !== pbit)
        $display("FAIL parity_bit d=%h k=%0d: serial got %b want %b", d, k, obs[k][2], pbit);
      else pass_cnt++;
    end
    check_cnt++;
    if (obs[45] !== 3'b101 || obs[44] !== 3'b110)
      $display("FAIL parity_done d=%h: k44 got %b want 110, k45 got %b want 101",
               d, obs[44], obs[45]);
    else pass_cnt++;
  endtask
`endif

  initial begin
    rst      = 1'b1;
    tx_start = 1'b0;
    tx_data  = 8'h00;
    test_reset();
    test_single(8'hA5);
    for (int i = 0; i < 4; i++) test_single(8'($urandom));
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
    test_parity(8'hA5, 1'b0);
    test_parity(8'h07, 1'b1);
`endif
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
